exm_stage_mc: RTL
=================

EXM_STAGE_MC -- requirements
Module: exm_stage_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath, memory address and memory data width.
REQ-002 SHALL have parameter PC_W, default 32: PC width; must be a multiple of DATA_W; BEATS = PC_W/DATA_W.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_valid, input, 1: decode presents an instruction.
REQ-006 SHALL have port o_ready, output, 1: stage accepts an instruction; accept = i_valid & o_ready.
REQ-007 SHALL have port i_alu_function, input, 3: ALU op per package encoding.
REQ-008 SHALL have port i_mem_op, input, 3: NONE/LOAD/STORE/PUSH/POP/PUSH_PC/POP_PC per package.
REQ-009 SHALL have port i_branch_operation, input, 1: conditional/unconditional branch.
REQ-010 SHALL have port i_branch_selector, input, 2: 00 Z, 01 N, 10 C, 11 always.
REQ-011 SHALL have port i_use_imm, input, 1: operand2 = i_immediate instead of i_data2.
REQ-012 SHALL have ports i_data1, i_data2 and i_immediate, input, DATA_W: operands.
REQ-013 SHALL have port i_pc, input, PC_W: return PC for PUSH_PC.
REQ-014 SHALL have ports o_mem_req and o_mem_we, output, 1: memory request and write enable.
REQ-015 SHALL have ports o_mem_addr and o_mem_wdata, output, DATA_W: memory address and write data.
REQ-016 SHALL have port i_mem_ack, input, 1: memory completes the current request this cycle.
REQ-017 SHALL have port i_mem_rdata, input, DATA_W: read data, valid with i_mem_ack.
REQ-018 SHALL have port o_valid, output, 1: one-cycle pulse, result outputs valid.
REQ-019 SHALL have ports o_ex_result and o_memory_data, output, DATA_W: ALU result and load/pop data.
REQ-020 SHALL have ports o_branch_decision, output, 1, and o_pc_new, output, PC_W: redirect and target.
REQ-021 SHALL have port o_flags, output, 3: {Z,N,C} flag register.

Function
REQ-022 SHALL define ALU ops as 0 PASS d1, 1 ADD, 2 SUB d1-op2, 3 AND, 4 OR, 5 NOT d1, 6 INC d1+1, 7 DEC d1-1; all arithmetic is modulo 2^DATA_W.
REQ-023 SHALL set C from carry-out on ADD/INC and borrow on SUB/DEC, hold C otherwise, and set Z/N from the result on every op except PASS.
REQ-024 SHALL update flags on accept, with results registered: o_valid rises exactly 1 cycle after accept for i_mem_op=NONE.
REQ-025 SHALL evaluate the branch on accept using the pre-update flags, with o_pc_new = zero-extended i_data1.
REQ-026 SHALL ignore i_branch_operation when i_mem_op is not NONE.
REQ-027 SHALL use FSM states IDLE, ACCESS and BEAT: IDLE accepts (o_ready=1); any memory op moves to ACCESS (single word) or BEAT (PC ops); after the final ack the FSM returns to IDLE with o_valid pulsed that cycle +1.
REQ-028 SHALL hold o_mem_req high with stable addr/data/we until i_mem_ack; i_mem_ack while req is low is ignored.
REQ-029 SHALL use addr=i_data1 for LOAD and addr=i_data1, wdata=i_data2 for STORE.
REQ-030 SHALL maintain an internal SP, DATA_W bits: PUSH writes i_data1 at SP then SP-1; POP sets SP+1 then reads at SP; SP wraps modulo 2^DATA_W, with no under/overflow detection.
REQ-031 SHALL make PUSH_PC BEATS writes, MS word first, SP decrementing per beat.
REQ-032 SHALL make POP_PC BEATS reads, LS word first, assemble the PC, then output o_branch_decision=1 and o_pc_new=assembled value with o_valid.
REQ-033 SHALL update SP on each ack, never on request.
REQ-034 SHALL keep o_ready low in ACCESS and BEAT, with i_valid ignored there.
REQ-035 SHALL keep o_branch_decision low whenever o_valid is low.

Reset
REQ-036 SHALL, on i_reset low, force state to IDLE, SP to all-ones, flags to 000, o_valid/o_mem_req/o_mem_we/o_branch_decision to 0, all data outputs to 0, and o_ready to 1 immediately.
REQ-037 SHALL abort any in-flight access on reset with no SP change retained; a late ack after reset is ignored.

Structure
REQ-038 SHALL place the ALU op enum, mem_op enum, branch selector codes and SP reset value in package exm_pkg.
REQ-039 SHALL implement the ALU as combinational sub-module exm_alu, parametrised by DATA_W; the FSM, SP and flags stay in the top.

Verification
REQ-040 SHALL cover: ADD d1=FFFF, imm=0001, use_imm=1 -> o_ex_result=0000, Z=1, C=1, o_valid 1 cycle later.
REQ-041 SHALL cover: Z=1 then JZ (sel 00) with SUB 5-5 in the same instruction, d1=0040 -> decision=1 (old Z), o_pc_new=00000040.
REQ-042 SHALL cover: PUSH d1=ABCD with ack delayed 3 cycles -> req held 3 cycles at addr FFFF, o_ready=0 throughout, SP=FFFE after.
REQ-043 SHALL cover: PUSH_PC i_pc=12345678 then POP_PC -> writes 1234@FFFF, 5678@FFFE; pop returns 12345678, decision=1, SP back to FFFF.
REQ-044 SHALL cover: POP from SP=FFFF -> SP wraps to 0000, read addr 0000.
REQ-045 SHALL cover: reset asserted during BEAT of PUSH_PC after the first ack -> IDLE, SP=FFFF, o_mem_req=0 immediately, subsequent stray ack ignored.

Source files
------------

// File: rtl/exm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exm_pkg
//  Description : Shared encodings for the multi-cycle execute/memory stage:
//                ALU operations, memory operations, branch selector codes,
//                stack-pointer reset fill and FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package exm_pkg;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_INC  = 3'd6,
    ALU_DEC  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_NONE    = 3'd0,
    MEM_LOAD    = 3'd1,
    MEM_STORE   = 3'd2,
    MEM_PUSH    = 3'd3,
    MEM_POP     = 3'd4,
    MEM_PUSH_PC = 3'd5,
    MEM_POP_PC  = 3'd6
  } mem_op_e;

  localparam logic [1:0] BR_SEL_Z      = 2'b00;
  localparam logic [1:0] BR_SEL_N      = 2'b01;
  localparam logic [1:0] BR_SEL_C      = 2'b10;
  localparam logic [1:0] BR_SEL_ALWAYS = 2'b11;

  // SP resets to all-ones; the fill bit is replicated to DATA_W in the top.
  localparam logic SP_RESET_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_BEAT   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/exm_alu.sv
`default_nettype none
// ============================================================================
//  Module      : exm_alu
//  Description : Combinational ALU for the execute stage. Produces the result,
//                the carry/borrow bit and enables telling the caller which
//                flags this operation is allowed to update.
//  Ports       : i_alu_function  op code (exm_pkg::alu_op_e)
//                i_a, i_b        operands (i_b = operand2)
//                o_result        result modulo 2^DATA_W
//                o_carry         carry-out (ADD/INC) or borrow (SUB/DEC)
//                o_carry_en      C flag must be written
//                o_zn_en         Z/N flags must be written
//  Revision    : 1.0  initial release
// ============================================================================
module exm_alu
  import exm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        i_alu_function,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_carry_en,
  output logic              o_zn_en
);

  localparam logic [DATA_W:0] C_ONE_W = (DATA_W+1)'(1);

  // One extra bit on top catches carry-out on add and borrow on subtract.
  logic [DATA_W:0] w_wide;

  always_comb begin
    w_wide     = '0;
    o_carry_en = 1'b0;
    o_zn_en    = 1'b1;
    case (alu_op_e'(i_alu_function))
      ALU_PASS: begin
        w_wide  = {1'b0, i_a};
        o_zn_en = 1'b0;
      end
      ALU_ADD: begin
        w_wide     = {1'b0, i_a} + {1'b0, i_b};
        o_carry_en = 1'b1;
      end
      ALU_SUB: begin
        w_wide     = {1'b0, i_a} - {1'b0, i_b};
        o_carry_en = 1'b1;
      end
      ALU_AND: w_wide = {1'b0, i_a & i_b};
      ALU_OR:  w_wide = {1'b0, i_a | i_b};
      ALU_NOT: w_wide = {1'b0, ~i_a};
      ALU_INC: begin
        w_wide     = {1'b0, i_a} + C_ONE_W;
        o_carry_en = 1'b1;
      end
      ALU_DEC: begin
        w_wide     = {1'b0, i_a} - C_ONE_W;
        o_carry_en = 1'b1;
      end
      default: w_wide = {1'b0, i_a};
    endcase
    o_result = w_wide[DATA_W-1:0];
    o_carry  = w_wide[DATA_W];
  end

endmodule
`default_nettype wire

// File: rtl/exm_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module      : exm_stage_mc
//  Description : Multi-cycle execute/memory stage. ALU ops and branches
//                complete one cycle after accept; memory ops (load, store,
//                push, pop and multi-beat PC push/pop) run a req/ack handshake
//                against a DATA_W-wide memory. Holds the {Z,N,C} flags and the
//                stack pointer. PC_W must be a multiple of DATA_W.
//  Ports       : i_clk / i_reset(async, active-low)
//                i_valid/o_ready         instruction handshake from decode
//                i_alu_function, i_mem_op, i_branch_operation,
//                i_branch_selector, i_use_imm, i_data1, i_data2,
//                i_immediate, i_pc       instruction fields
//                o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata,
//                i_mem_ack/i_mem_rdata   memory port
//                o_valid, o_ex_result, o_memory_data,
//                o_branch_decision, o_pc_new, o_flags   results
//  Revision    : 1.0  initial release
// ============================================================================
module exm_stage_mc
  import exm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_alu_function,
  input  logic [2:0]        i_mem_op,
  input  logic              i_branch_operation,
  input  logic [1:0]        i_branch_selector,
  input  logic              i_use_imm,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_immediate,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_ex_result,
  output logic [DATA_W-1:0] o_memory_data,
  output logic              o_branch_decision,
  output logic [PC_W-1:0]   o_pc_new,
  output logic [2:0]        o_flags
);

  localparam int BEATS  = PC_W / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [DATA_W-1:0] C_SP_RESET = {DATA_W{SP_RESET_FILL}};
  localparam logic [DATA_W-1:0] C_ONE      = DATA_W'(1);
  localparam logic [BEAT_W-1:0] C_LAST     = BEAT_W'(BEATS - 1);

  state_e              r_state, w_state_next;
  mem_op_e             r_op;
  logic [DATA_W-1:0]   r_sp;
  logic [2:0]          r_flags, w_flags_next;      // {Z,N,C}
  logic [BEAT_W-1:0]   r_beat;
  logic [PC_W-1:0]     r_pc_shift;                 // PC words to push / being assembled
  logic                r_mem_req, r_mem_we;
  logic [DATA_W-1:0]   r_mem_addr, r_mem_wdata;
  logic                r_valid, r_branch;
  logic [DATA_W-1:0]   r_ex_result, r_memory_data;
  logic [PC_W-1:0]     r_pc_new;

  logic [DATA_W-1:0]   w_op2, w_alu_result;
  logic                w_alu_c, w_alu_c_en, w_alu_zn_en;
  logic                w_accept, w_ack, w_last_beat, w_cond, w_take;
  logic [PC_W-1:0]     w_rd_ext, w_pc_asm;

  exm_alu #(.DATA_W(DATA_W)) u_alu (
    .i_alu_function (i_alu_function),
    .i_a            (i_data1),
    .i_b            (w_op2),
    .o_result       (w_alu_result),
    .o_carry        (w_alu_c),
    .o_carry_en     (w_alu_c_en),
    .o_zn_en        (w_alu_zn_en)
  );

  always_comb begin
    w_op2       = i_use_imm ? i_immediate : i_data2;
    w_accept    = i_valid && (r_state == ST_IDLE);
    // An ack only counts while a request is actually outstanding.
    w_ack       = r_mem_req && i_mem_ack;
    w_last_beat = (r_beat == C_LAST);

    // POP_PC reads LS word first: each new word enters at the top and the
    // accumulated value shifts down, so after BEATS reads it is in place.
    w_rd_ext = PC_W'(i_mem_rdata) << (PC_W - DATA_W);
    w_pc_asm = (r_pc_shift >> DATA_W) | w_rd_ext;

    w_flags_next = r_flags;
    if (w_alu_zn_en) begin
      w_flags_next[2] = (w_alu_result == '0);
      w_flags_next[1] = w_alu_result[DATA_W-1];
    end
    if (w_alu_c_en) begin
      w_flags_next[0] = w_alu_c;
    end

    // Branch condition uses the flags as they were before this instruction.
    case (i_branch_selector)
      BR_SEL_Z: w_cond = r_flags[2];
      BR_SEL_N: w_cond = r_flags[1];
      BR_SEL_C: w_cond = r_flags[0];
      default:  w_cond = 1'b1;
    endcase
    w_take = i_branch_operation && w_cond;

    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (mem_op_e'(i_mem_op))
            MEM_LOAD, MEM_STORE, MEM_PUSH, MEM_POP: w_state_next = ST_ACCESS;
            MEM_PUSH_PC, MEM_POP_PC:               w_state_next = ST_BEAT;
            default:                               w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_ACCESS: if (w_ack) w_state_next = ST_IDLE;
      ST_BEAT:   if (w_ack && w_last_beat) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op          <= MEM_NONE;
      r_sp          <= C_SP_RESET;
      r_flags       <= 3'b000;
      r_beat        <= '0;
      r_pc_shift    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_valid       <= 1'b0;
      r_branch      <= 1'b0;
      r_ex_result   <= '0;
      r_memory_data <= '0;
      r_pc_new      <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_branch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_flags     <= w_flags_next;
            r_ex_result <= w_alu_result;
            r_op        <= mem_op_e'(i_mem_op);
            r_beat      <= '0;
            case (mem_op_e'(i_mem_op))
              MEM_LOAD: begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= i_data1;
              end
              MEM_STORE: begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= i_data1;
                r_mem_wdata <= i_data2;
              end
              MEM_PUSH: begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_sp;
                r_mem_wdata <= i_data1;
              end
              MEM_POP: begin
                // Pre-increment: read at SP+1, SP itself moves on the ack.
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= r_sp + C_ONE;
              end
              MEM_PUSH_PC: begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_sp;
                r_mem_wdata <= i_pc[PC_W-1 -: DATA_W];
                r_pc_shift  <= i_pc << DATA_W;
              end
              MEM_POP_PC: begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= r_sp + C_ONE;
                r_pc_shift <= '0;
              end
              default: begin
                r_valid  <= 1'b1;
                r_branch <= w_take;
                r_pc_new <= PC_W'(i_data1);
              end
            endcase
          end
        end
        ST_ACCESS: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_valid   <= 1'b1;
            case (r_op)
              MEM_PUSH: r_sp <= r_sp - C_ONE;
              MEM_POP:  r_sp <= r_sp + C_ONE;
              default:  r_sp <= r_sp;
            endcase
            if (!r_mem_we) begin
              r_memory_data <= i_mem_rdata;
            end
          end
        end
        ST_BEAT: begin
          if (w_ack) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (r_mem_we) begin
              r_sp        <= r_sp - C_ONE;
              r_mem_addr  <= r_mem_addr - C_ONE;
              r_mem_wdata <= r_pc_shift[PC_W-1 -: DATA_W];
              r_pc_shift  <= r_pc_shift << DATA_W;
            end else begin
              r_sp       <= r_sp + C_ONE;
              r_mem_addr <= r_mem_addr + C_ONE;
              r_pc_shift <= w_pc_asm;
            end
            if (w_last_beat) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_valid   <= 1'b1;
              if (!r_mem_we) begin
                r_branch <= 1'b1;
                r_pc_new <= w_pc_asm;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready           = (r_state == ST_IDLE);
  assign o_mem_req         = r_mem_req;
  assign o_mem_we          = r_mem_we;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_wdata       = r_mem_wdata;
  assign o_valid           = r_valid;
  assign o_ex_result       = r_ex_result;
  assign o_memory_data     = r_memory_data;
  assign o_branch_decision = r_branch;
  assign o_pc_new          = r_pc_new;
  assign o_flags           = r_flags;

endmodule
`default_nettype wire
